viterbi_frame_decoder: RTL and testbench
========================================

VITERBI_FRAME_DECODER -- requirements
Module: viterbi_frame_decoder

Interface
REQ-001 SHALL have parameter STATES, default 4, meaning trellis states (power of 2); STATE_BITS = log2(STATES).
REQ-002 SHALL have parameter NOUT, default 2, meaning coded bits per symbol.
REQ-003 SHALL have parameter POLY[NOUT], default '{7,5}, meaning feedforward generator taps over {input,state}.
REQ-004 SHALL have parameter LLR_W, default 6, meaning signed soft-input width.
REQ-005 SHALL have parameter PM_W, default 12, meaning signed path-metric width.
REQ-006 SHALL have parameter FRAME_MAX, default 64, meaning maximum data bits per frame.
REQ-007 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset.
REQ-008 SHALL have ports: in_valid  in  1; in_ready  out  1; in_llr  in  NOUT x LLR_W signed, in_llr[k] for coded bit k (positive means 1); in_last  in  1, final (tail) symbol of frame.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_bit  out  1; out_last  out  1; frame_err  out  1, one-cycle error pulse.
REQ-010 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.

Function
REQ-011 SHALL use trellis next = {u, s[STATE_BITS-1:1]}, coded bit k = XOR of ({u,s} AND POLY[k]); non-recursive only.
REQ-012 SHALL compute branch metric as sum over k of +in_llr[k] if hypothesised bit is 1, else -in_llr[k]; metrics are maximised (max-product).
REQ-013 SHALL initialise path metrics at frame start: state 0 = 0, others = -2^(PM_W-3).
REQ-014 SHALL perform one ACS over all states per accepted symbol, same cycle as the handshake; predecessors are (s<<1)|0 and (s<<1)|1 (masked); decided bit u = s[MSB].
REQ-015 SHALL break ties toward the lower-numbered predecessor.
REQ-016 SHALL, after each ACS, subtract the maximum new metric from all metrics (best metric = 0); arithmetic saturates at PM_W.
REQ-017 SHALL keep a register-exchange survivor of FRAME_MAX+STATE_BITS bits per state, appending u of the chosen branch.
REQ-018 SHALL use FSM IDLE -> ACS on first accepted symbol; ACS -> OUT on accepted in_last; OUT -> IDLE after handshake of out_last.
REQ-019 SHALL drive in_ready = 1 in IDLE/ACS and 0 in OUT.
REQ-020 SHALL treat the frame as terminated: the decode path is survivor of state 0; last STATE_BITS decisions are tail and are not emitted.
REQ-021 SHALL emit N-STATE_BITS bits (N = symbols received), oldest first, first out_valid the cycle after the in_last handshake; out_last is set with the final bit.
REQ-022 SHALL hold out_bit/out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, for a frame with N <= STATE_BITS, emit nothing, pulse frame_err, and return to IDLE.
REQ-024 SHALL, for N > FRAME_MAX+STATE_BITS, keep accepting symbols without ACS until in_last, pulse frame_err at in_last, emit nothing.
REQ-025 SHALL accept in_last in IDLE as a one-symbol frame (REQ-023 applies).

Reset
REQ-026 SHALL on rst_n low, at any time: state IDLE, in_ready 0 during reset then 1; out_valid 0, out_bit 0, out_last 0, frame_err 0; metrics and survivors cleared; partial frame discarded.

Structure
REQ-027 SHALL place the state, symbol and path-metric typedefs and the next-state/output functions in shared package trellis_pkg, consistent with trellis_if.
REQ-028 SHALL use one sub-module, viterbi_acs, one instance per state (two-way add-compare-select plus decision bit).

Verification
REQ-029 SHALL test clean decode: data 1,0,1,1 plus tail 0,0 -> symbols 11,10,00,01,01,11 as LLR +/-31 -> out 1,0,1,1, out_last on 4th.
REQ-030 SHALL test single error: same frame with symbol 3 = 10 -> out still 1,0,1,1.
REQ-031 SHALL test backpressure: out_ready toggling 1-in-3 -> identical bit sequence, out_bit stable while stalled, in_ready 0 throughout OUT.
REQ-032 SHALL test short frame: 2 symbols with in_last -> no out_valid, frame_err one cycle.
REQ-033 SHALL test reset mid-frame: assert rst_n low after 3 symbols, then send clean frame -> correct 1,0,1,1 with no residue.
REQ-034 SHALL test max/overlength: 66 symbols of all-zero data -> 64 zeros; 67 symbols -> frame_err, no output.

Source files
------------

// File: rtl/trellis_pkg.sv
// Shared trellis definitions for the frame-terminated Viterbi decoder:
// FSM encoding, default-width typedefs and the trellis next-state/output functions.
package trellis_pkg;

  localparam int DEF_STATES     = 4;
  localparam int DEF_STATE_BITS = $clog2(DEF_STATES);
  localparam int DEF_NOUT       = 2;
  localparam int DEF_LLR_W      = 6;
  localparam int DEF_PM_W       = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACS  = 2'd1,
    ST_OUT  = 2'd2
  } fsm_state_t;

  typedef logic [DEF_STATE_BITS-1:0]                state_t;
  typedef logic [DEF_NOUT-1:0][DEF_LLR_W-1:0]       symbol_t;
  typedef logic signed [DEF_PM_W-1:0]               pm_t;

  // Shift register view: the new input bit enters at the top, the oldest bit drops out.
  function automatic int next_state(input int s, input int u, input int sb);
    return (u << (sb - 1)) | (s >> 1);
  endfunction

  function automatic int pred_state(input int n, input int b, input int states);
    return (n * 2 + b) % states;
  endfunction

  // Coded bit for a feedforward generator over the register {u, s}.
  function automatic logic coded_bit(input int s, input int u, input int sb, input int poly);
    int r;
    r = (u << sb) | s;
    return ^(r & poly);
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Two-way add-compare-select for one trellis state with saturating path metric.
module viterbi_acs #(
  parameter int PM_W = 12,
  parameter int BM_W = 8
) (
  input  logic signed [PM_W-1:0] pm0,
  input  logic signed [PM_W-1:0] pm1,
  input  logic signed [BM_W-1:0] bm0,
  input  logic signed [BM_W-1:0] bm1,
  output logic signed [PM_W-1:0] pm_out,
  output logic                   dec
);

  localparam logic signed [PM_W-1:0] PM_MAX = {1'b0, {(PM_W-1){1'b1}}};
  localparam logic signed [PM_W-1:0] PM_MIN = {1'b1, {(PM_W-1){1'b0}}};

  logic signed [PM_W:0] sum0;
  logic signed [PM_W:0] sum1;
  logic signed [PM_W:0] best;

  assign sum0 = {pm0[PM_W-1], pm0} + {{(PM_W+1-BM_W){bm0[BM_W-1]}}, bm0};
  assign sum1 = {pm1[PM_W-1], pm1} + {{(PM_W+1-BM_W){bm1[BM_W-1]}}, bm1};

  // Strict compare: equal metrics keep the lower-numbered predecessor.
  assign dec  = (sum1 > sum0);
  assign best = dec ? sum1 : sum0;

  always_comb begin
    if (best[PM_W] != best[PM_W-1]) begin
      pm_out = best[PM_W] ? PM_MIN : PM_MAX;
    end else begin
      pm_out = best[PM_W-1:0];
    end
  end

endmodule

// File: rtl/viterbi_frame_decoder.sv
// Frame-terminated soft-input Viterbi decoder with register-exchange survivors.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
module viterbi_frame_decoder
  import trellis_pkg::*;
#(
  parameter int STATES    = 4,
  parameter int NOUT      = 2,
  parameter int POLY [NOUT] = '{7, 5},
  parameter int LLR_W     = 6,
  parameter int PM_W      = 12,
  parameter int FRAME_MAX = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NOUT-1:0][LLR_W-1:0]  in_llr,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_bit,
  output logic                        out_last,
  output logic                        frame_err,
  output fsm_state_t                  dbg_state
);

  localparam int SB    = $clog2(STATES);
  localparam int SL    = FRAME_MAX + SB;
  localparam int CNT_W = $clog2(SL + 1);
  localparam int BM_W  = LLR_W + $clog2(NOUT) + 1;

  localparam logic [CNT_W-1:0]       SL_C    = CNT_W'(SL);
  localparam logic [CNT_W-1:0]       SB_C    = CNT_W'(SB);
  localparam logic [CNT_W-1:0]       ONE     = CNT_W'(1);
  localparam logic signed [PM_W-1:0] PM_INIT = PM_W'(-(2 ** (PM_W - 3)));
  localparam logic signed [PM_W-1:0] PM_MIN  = {1'b1, {(PM_W-1){1'b0}}};

  fsm_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       out_idx_q;
  logic [CNT_W-1:0]       last_idx_q;
  logic signed [PM_W-1:0] pm_q     [STATES];
  logic signed [PM_W-1:0] pm_src   [STATES];
  logic signed [PM_W-1:0] pm_acs   [STATES];
  logic signed [PM_W-1:0] pm_norm  [STATES];
  logic signed [PM_W-1:0] pm_max;
  logic [SL-1:0]          surv_q   [STATES];
  logic [SL-1:0]          surv_src [STATES];
  logic [SL-1:0]          surv_new [STATES];
  logic                   dec      [STATES];
  logic signed [BM_W-1:0] llr_ext  [NOUT];
  logic                   accept;
  logic                   do_acs;
  logic                   last_bad;

  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  // Once the survivor is full, symbols are still accepted but no longer decoded.
  assign do_acs    = accept && (cnt_q < SL_C);
  assign last_bad  = (cnt_q >= SL_C) || (cnt_q < SB_C);

  always_comb begin
    for (int k = 0; k < NOUT; k++) begin
      llr_ext[k] = {{(BM_W-LLR_W){in_llr[k][LLR_W-1]}}, in_llr[k]};
    end
  end

  // In IDLE the next symbol starts a new frame, so ACS reads the start-of-frame metrics.
  always_comb begin
    for (int n = 0; n < STATES; n++) begin
      if (state_q == ST_IDLE) begin
        pm_src[n]   = (n == 0) ? '0 : PM_INIT;
        surv_src[n] = '0;
      end else begin
        pm_src[n]   = pm_q[n];
        surv_src[n] = surv_q[n];
      end
    end
  end

  for (genvar n = 0; n < STATES; n++) begin : g_state
    localparam int P0 = pred_state(n, 0, STATES);
    localparam int P1 = pred_state(n, 1, STATES);
    localparam int U  = n / (STATES / 2);

    logic signed [BM_W-1:0] bm0;
    logic signed [BM_W-1:0] bm1;
    logic [SL-1:0]          surv_g;
    logic signed [PM_W:0]   diff;

    always_comb begin
      bm0 = '0;
      bm1 = '0;
      for (int k = 0; k < NOUT; k++) begin
        bm0 = coded_bit(P0, U, SB, POLY[k]) ? (bm0 + llr_ext[k]) : (bm0 - llr_ext[k]);
        bm1 = coded_bit(P1, U, SB, POLY[k]) ? (bm1 + llr_ext[k]) : (bm1 - llr_ext[k]);
      end
    end

    viterbi_acs #(
      .PM_W (PM_W),
      .BM_W (BM_W)
    ) u_acs (
      .pm0    (pm_src[P0]),
      .pm1    (pm_src[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_out (pm_acs[n]),
      .dec    (dec[n])
    );

    // Survivor bit i holds the decision for symbol i, so the oldest bit is bit 0.
    always_comb begin
      surv_g        = dec[n] ? surv_src[P1] : surv_src[P0];
      surv_g[cnt_q] = 1'(U);
    end
    assign surv_new[n] = surv_g;

    assign diff       = {pm_acs[n][PM_W-1], pm_acs[n]} - {pm_max[PM_W-1], pm_max};
    assign pm_norm[n] = (diff[PM_W] != diff[PM_W-1]) ? PM_MIN : diff[PM_W-1:0];
  end

  always_comb begin
    pm_max = pm_acs[0];
    for (int n = 1; n < STATES; n++) begin
      if (pm_acs[n] > pm_max) pm_max = pm_acs[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_idx_q  <= '0;
      last_idx_q <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_last   <= 1'b0;
      frame_err  <= 1'b0;
      for (int n = 0; n < STATES; n++) begin
        pm_q[n]   <= '0;
        surv_q[n] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ACS: begin
          in_ready <= 1'b1;
          if (accept) begin
            state_q <= ST_ACS;
            if (do_acs) begin
              pm_q   <= pm_norm;
              surv_q <= surv_new;
              cnt_q  <= cnt_q + ONE;
            end
            if (in_last) begin
              cnt_q <= '0;
              if (last_bad) begin
                frame_err <= 1'b1;
                state_q   <= ST_IDLE;
              end else begin
                // Terminated trellis: state 0 survivor is the decode path, tail bits dropped.
                state_q    <= ST_OUT;
                in_ready   <= 1'b0;
                out_valid  <= 1'b1;
                out_idx_q  <= '0;
                last_idx_q <= cnt_q - SB_C;
                out_bit    <= surv_new[0][0];
                out_last   <= (cnt_q == SB_C);
              end
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= ST_IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_bit   <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_idx_q <= out_idx_q + ONE;
              out_bit   <= surv_q[0][out_idx_q + ONE];
              out_last  <= ((out_idx_q + ONE) == last_idx_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// Directed bench for viterbi_frame_decoder: clean, corrupted, stalled, short,
// reset-interrupted, maximum and overlength frames against hand-computed bits.
module tb_viterbi_frame_decoder;
  import trellis_pkg::*;

  localparam logic [5:0] LLR_P = 6'd31;
  localparam logic [5:0] LLR_N = 6'h21;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0][5:0] in_llr;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic            out_bit;
  logic            out_last;
  logic            frame_err;
  fsm_state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];
  logic [1:0] sym_q[$];

  viterbi_frame_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_llr    (in_llr),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one symbol, called at a negedge, returns at the next negedge
  task automatic send_sym(input logic [1:0] s, input logic last);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_llr[0] = s[1] ? LLR_P : LLR_N;
    in_llr[1] = s[0] ? LLR_P : LLR_N;
    in_last   = last;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic send_frame();
    int n;
    n = sym_q.size();
    for (int i = 0; i < n; i++) send_sym(sym_q[i], (i == n - 1));
    sym_q.delete();
  endtask

  task automatic load_clean(input logic corrupt);
    sym_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    if (corrupt) sym_q[2] = 2'b10;
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
  endtask

  // scoreboard: drains exp_q, out_ready high one cycle in every `period`
  task automatic collect(input int period);
    int   cyc;
    logic held;
    logic hbit;
    logic hlast;
    logic done;
    logic [0:0] e;
    cyc  = 0;
    held = 1'b0;
    hbit = 1'b0;
    hlast = 1'b0;
    done = 1'b0;
    check("first_valid", out_valid, 1);
    while (!done && cyc < 400) begin
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_bit", out_bit, hbit);
        check("stall_last", out_last, hlast);
      end
      if (out_valid) check("in_ready_out", in_ready, 0);
      out_ready = ((cyc % period) == 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", out_valid, 0);
          done = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("out_bit", out_bit, e);
          check("out_last", out_last, (exp_q.size() == 0));
          if (out_last) done = 1'b1;
        end
      end
      held  = out_valid && !out_ready;
      hbit  = out_bit;
      hlast = out_last;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("frame_done", done, 1);
    check("exp_left", exp_q.size(), 0);
    check("post_valid", out_valid, 0);
    check("post_state", dbg_state, ST_IDLE);
  endtask

  task automatic expect_err();
    check("err_pulse", frame_err, 1);
    check("err_no_valid", out_valid, 0);
    @(negedge clk);
    check("err_one_cycle", frame_err, 0);
    check("err_state", dbg_state, ST_IDLE);
    repeat (4) begin
      @(negedge clk);
      check("err_quiet", out_valid, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_llr    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // clean frame
    load_clean(1'b0);
    send_frame();
    check("clean_no_err", frame_err, 0);
    collect(1);

    // single coded-bit error in the third symbol
    load_clean(1'b1);
    send_frame();
    collect(1);

    // backpressure: ready one cycle in three
    load_clean(1'b0);
    send_frame();
    collect(3);

    // short frames: two symbols, then a lone in_last from IDLE
    sym_q = '{2'b11, 2'b10};
    send_frame();
    expect_err();
    sym_q = '{2'b11};
    send_frame();
    expect_err();

    // reset in the middle of a frame
    send_sym(2'b11, 1'b0);
    send_sym(2'b10, 1'b0);
    send_sym(2'b00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    load_clean(1'b0);
    send_frame();
    collect(1);

    // maximum frame: 64 data zeros + 2 tail
    for (int i = 0; i < 66; i++) sym_q.push_back(2'b00);
    for (int i = 0; i < 64; i++) exp_q.push_back(1'b0);
    send_frame();
    collect(1);

    // overlength frame: 67 symbols
    for (int i = 0; i < 67; i++) sym_q.push_back(2'b00);
    send_frame();
    expect_err();

    // decoder still healthy afterwards
    load_clean(1'b0);
    send_frame();
    collect(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
